// File: rtl/jt89_pkg.sv
// Shared constants for the jt89 output conditioning stage: default tracker pole, output width
// and helpers that derive the saturation limits from the output width.
package jt89_pkg;

  localparam int JT89_K_DEF  = 8;
  localparam int JT89_OW_DEF = 12;
  localparam int JT89_ZW     = 16;

  function automatic logic signed [JT89_ZW-1:0] sat_max(input int ow);
    return JT89_ZW'((32'sd1 <<< (ow - 1)) - 32'sd1);
  endfunction

  function automatic logic signed [JT89_ZW-1:0] sat_min(input int ow);
    return JT89_ZW'(-(32'sd1 <<< (ow - 1)));
  endfunction

endpackage

// File: rtl/jt89_sat.sv
// Combinational saturator: clamps a 16-bit signed value into OW signed bits and flags clipping.
module jt89_sat
  import jt89_pkg::*;
#(
  parameter int OW = JT89_OW_DEF
) (
  input  logic signed [JT89_ZW-1:0] i_z,
  output logic signed [OW-1:0]      o_y,
  output logic                      o_clip
);

  localparam logic signed [JT89_ZW-1:0] SAT_HI = sat_max(OW);
  localparam logic signed [JT89_ZW-1:0] SAT_LO = sat_min(OW);

  always_comb begin
    o_clip = 1'b0;
    o_y    = i_z[OW-1:0];
    if (i_z > SAT_HI) begin
      o_y    = SAT_HI[OW-1:0];
      o_clip = 1'b1;
    end else if (i_z < SAT_LO) begin
      o_y    = SAT_LO[OW-1:0];
      o_clip = 1'b1;
    end
  end

endmodule

// File: rtl/jt89_out.sv
// Output conditioning for the jt89 PSG mix: sample on cen, optional DC removal, 0..3 bit gain,
// saturation to OW bits, one-cycle sample strobe and sticky clip flag.
module jt89_out
  import jt89_pkg::*;
#(
  parameter int K  = JT89_K_DEF,
  parameter int OW = JT89_OW_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cen,
  input  logic signed [11:0]   sound,
  input  logic                 dc_en,
  input  logic [1:0]           gain,
  input  logic                 peak_clr,
  output logic signed [OW-1:0] snd_out,
  output logic                 sample,
  output logic                 peak
);

  localparam int AW = 13 + K;

  logic signed [AW-1:0]      r_acc;
  logic signed [11:0]        r_x;
  logic signed [12:0]        r_dc;
  logic                      r_v1;

  logic signed [AW-1:0]      w_acc_shr;
  logic signed [AW-1:0]      w_sound_ext;
  logic signed [12:0]        w_dc_use;
  logic signed [12:0]        w_y;
  logic signed [JT89_ZW-1:0] w_y_ext;
  logic signed [JT89_ZW-1:0] w_z;
  logic signed [OW-1:0]      w_sat;
  logic                      w_clip;

  // acc>>>K always fits in 13 bits because acc stays within the 12-bit input range scaled by 2^K
  assign w_acc_shr   = r_acc >>> K;
  assign w_sound_ext = {{(AW-12){sound[11]}}, sound};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
      r_x   <= '0;
      r_dc  <= '0;
      r_v1  <= 1'b0;
    end else begin
      r_v1 <= cen;
      if (cen) begin
        r_x  <= sound;
        r_dc <= dc_en ? w_acc_shr[12:0] : 13'sd0;
      end
      if (!dc_en)
        r_acc <= '0;
      else if (cen)
        r_acc <= r_acc + w_sound_ext - w_acc_shr;
    end
  end

  assign w_dc_use = dc_en ? r_dc : 13'sd0;
  assign w_y      = {r_x[11], r_x} - w_dc_use;
  assign w_y_ext  = {{(JT89_ZW-13){w_y[12]}}, w_y};
  assign w_z      = w_y_ext <<< gain;

  jt89_sat #(.OW(OW)) u_sat (
    .i_z    (w_z),
    .o_y    (w_sat),
    .o_clip (w_clip)
  );

  // A clip on the same edge as peak_clr keeps the flag set
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snd_out <= '0;
      sample  <= 1'b0;
      peak    <= 1'b0;
    end else begin
      sample <= r_v1;
      if (r_v1)
        snd_out <= w_sat;
      if (r_v1 && w_clip)
        peak <= 1'b1;
      else if (peak_clr)
        peak <= 1'b0;
    end
  end

endmodule

// File: tb/tb_jt89_out.sv
// Directed self-checking bench for jt89_out (K=4, OW=12); outputs sampled 1 time unit after posedge.
module tb_jt89_out;

  logic               clk;
  logic               rst;
  logic               cen;
  logic signed [11:0] sound;
  logic               dc_en;
  logic [1:0]         gain;
  logic               peak_clr;
  logic signed [11:0] snd_out;
  logic               sample;
  logic               peak;

  int n_checks;
  int n_fail;

  jt89_out #(.K(4), .OW(12)) dut (
    .clk      (clk),
    .rst      (rst),
    .cen      (cen),
    .sound    (sound),
    .dc_en    (dc_en),
    .gain     (gain),
    .peak_clr (peak_clr),
    .snd_out  (snd_out),
    .sample   (sample),
    .peak     (peak)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  task automatic do_reset();
    cen = 1'b0; sound = '0; dc_en = 1'b0; gain = 2'd0; peak_clr = 1'b0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    chk("reset snd_out", int'(snd_out), 0);
    chk("reset sample", int'(sample), 0);
    chk("reset peak", int'(peak), 0);
  endtask

  task automatic test_passthrough();
    do_reset();
    dc_en = 1'b0; gain = 2'd0; cen = 1'b1; sound = 12'sd256;
    tick();
    chk("pass sample after edge1", int'(sample), 0);
    tick();
    chk("pass snd_out after edge2", int'(snd_out), 256);
    chk("pass sample after edge2", int'(sample), 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("pass sample held", int'(sample), 1);
    end
    cen = 1'b0;
    tick(); tick();
  endtask

  task automatic test_saturation();
    do_reset();
    gain = 2'd3; cen = 1'b1; sound = 12'sd300;
    tick(); tick();
    chk("sat pos snd_out", int'(snd_out), 2047);
    chk("sat pos peak", int'(peak), 1);
    sound = -12'sd300;
    tick(); tick();
    chk("sat neg snd_out", int'(snd_out), -2048);
    cen = 1'b0;
    tick(); tick(); tick();
    chk("sat peak sticky", int'(peak), 1);
    peak_clr = 1'b1;
    tick();
    peak_clr = 1'b0;
    chk("sat peak cleared", int'(peak), 0);
    gain = 2'd0;
  endtask

  task automatic test_dc_removal();
    int prev;
    int zero_seen;
    do_reset();
    dc_en = 1'b1; gain = 2'd0; cen = 1'b1; sound = 12'sd1000;
    tick(); tick();
    chk("dc first output", int'(snd_out), 1000);
    prev = int'(snd_out);
    tick();
    // second output: dc_r = 1000>>>4 = 62
    chk("dc second output", int'(snd_out), 938);
    zero_seen = 0;
    for (int i = 0; i < 400; i++) begin
      if (int'(snd_out) > prev) begin
        n_fail++;
        $display("FAIL dc monotonic: got %0d expected <= %0d", int'(snd_out), prev);
      end
      if (zero_seen != 0 && snd_out !== 12'sd0) begin
        n_fail++;
        $display("FAIL dc stays zero: got %0d expected 0", int'(snd_out));
      end
      n_checks++;
      if (snd_out === 12'sd0) zero_seen = 1;
      prev = int'(snd_out);
      tick();
    end
    chk("dc reached zero", zero_seen, 1);
    chk("dc final output", int'(snd_out), 0);
    cen = 1'b0; dc_en = 1'b0;
    tick();
  endtask

  task automatic test_enable_gating();
    int vals[3] = '{10, 20, 30};
    do_reset();
    for (int s = 0; s < 3; s++) begin
      cen = 1'b1; sound = 12'(vals[s]);
      tick();
      cen = 1'b0;
      chk("gate sample at cen edge", int'(sample), 0);
      tick();
      chk("gate sample pulse", int'(sample), 1);
      chk("gate snd_out", int'(snd_out), vals[s]);
      tick();
      chk("gate sample low", int'(sample), 0);
      chk("gate snd_out held", int'(snd_out), vals[s]);
      tick();
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    gain = 2'd3; cen = 1'b1; sound = 12'sd300;
    tick(); tick(); tick();
    chk("arst pre peak", int'(peak), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst snd_out", int'(snd_out), 0);
    chk("arst sample", int'(sample), 0);
    chk("arst peak", int'(peak), 0);
    cen = 1'b0; gain = 2'd0; sound = 12'sd77;
    tick();
    #3;
    rst = 1'b0;
    tick();
    chk("arst idle sample", int'(sample), 0);
    cen = 1'b1;
    tick();
    cen = 1'b0;
    chk("arst sample at first cen", int'(sample), 0);
    tick();
    chk("arst sample after cen", int'(sample), 1);
    chk("arst snd_out after cen", int'(snd_out), 77);
  endtask

  task automatic test_clip_and_clear();
    do_reset();
    gain = 2'd3; sound = 12'sd2047; cen = 1'b1; peak_clr = 1'b1;
    tick();
    cen = 1'b0;
    chk("clr no clip yet", int'(peak), 0);
    tick();
    chk("clr clip wins", int'(peak), 1);
    chk("clr snd_out", int'(snd_out), 2047);
    tick();
    chk("clr clears later", int'(peak), 0);
    peak_clr = 1'b0;
    gain = 2'd0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1; cen = 1'b0; sound = '0; dc_en = 1'b0; gain = 2'd0; peak_clr = 1'b0;
    test_reset();
    test_passthrough();
    test_saturation();
    test_dc_removal();
    test_enable_gating();
    test_async_reset();
    test_clip_and_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
